// File: rtl/ptp_int_svc_pkg.sv
// Shared types and constants for the PTP interrupt-servicing initiator.
package ptp_int_pkg;

    // Servicing FSM. WR_MASK is encoded as zero because it is the reset state.
    typedef enum logic [2:0] {
        ST_WR_MASK  = 3'd0,
        ST_RD_MASK  = 3'd1,
        ST_IDLE     = 3'd2,
        ST_RD_STAT  = 3'd3,
        ST_DISPATCH = 3'd4,
        ST_HOLDOFF  = 3'd5
    } state_e;

    // Register offsets relative to INT_BASE_ADDR.
    localparam logic [31:0] STAT_OFS = 32'd0;
    localparam logic [31:0] MASK_OFS = 32'd1;

    // Bit positions of the three interrupt sources in mask and status words.
    localparam int XMS = 2;
    localparam int RX  = 1;
    localparam int TX  = 0;

    typedef logic [2:0] src_t;

endpackage

// File: rtl/ptp_int_svc_if.sv
// Bus between this initiator (master) and the interrupt controller (slave).
interface ptp_int_svc_if;
    logic [31:0] bus2ip_addr;
    logic [31:0] bus2ip_data;
    logic        bus2ip_rd_ce;
    logic        bus2ip_wr_ce;
    logic [31:0] ip2bus_data;

    modport master (
        output bus2ip_addr, bus2ip_data, bus2ip_rd_ce, bus2ip_wr_ce,
        input  ip2bus_data
    );

    modport slave (
        input  bus2ip_addr, bus2ip_data, bus2ip_rd_ce, bus2ip_wr_ce,
        output ip2bus_data
    );
endinterface

// File: rtl/ptp_int_svc_evt_cnt.sv
// Saturating event counter: counts inc_i pulses and sticks at all-ones.
module ptp_evt_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Increment on each pulse unless already saturated.
    always_comb begin
        // NOTE: default-assign every always_comb output first so no path leaves it unassigned (no latch).
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register, cleared only by reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ptp_int_svc.sv
// Interrupt-servicing bus initiator: programs the controller mask, reads the
// read-clear status on interrupt and dispatches per-source event pulses/counts.
module ptp_int_svc
    import ptp_int_pkg::*;
#(
    parameter logic [31:0] INT_BASE_ADDR = 32'h0,
    parameter int          HOLDOFF       = 6,
    parameter int          CNT_W         = 16
) (
    input  logic             bus2ip_clk,
    input  logic             bus2ip_rst_n,
    input  logic             int_ptp_i,
    ptp_int_svc_if.master    bus,
    input  logic [2:0]       cfg_mask_i,
    output logic             evt_xms_o,
    output logic             evt_rx_o,
    output logic             evt_tx_o,
    output logic [CNT_W-1:0] cnt_xms_o,
    output logic [CNT_W-1:0] cnt_rx_o,
    output logic [CNT_W-1:0] cnt_tx_o,
    output logic [2:0]       last_status_o,
    output logic             cfg_err_o,
    output logic             busy_o
);

    localparam int             HW        = (HOLDOFF > 2) ? $clog2(HOLDOFF) : 1;
    localparam logic [HW-1:0]  HOLD_LOAD = HW'(HOLDOFF - 1);

    state_e        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    src_t          mask_q, mask_d;
    src_t          status_q, status_d;
    logic          err_q, err_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          rd_ce, wr_ce;
    src_t          evt;
    logic          unused_rdata_hi;

    assign unused_rdata_hi = ^bus.ip2bus_data[31:3];

    // State register; reset lands in WR_MASK so the mask is programmed first.
    always_ff @(posedge bus2ip_clk) begin
        if (!bus2ip_rst_n) begin
            state_q <= ST_WR_MASK;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a mask change in IDLE wins over a pending interrupt.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_WR_MASK:  state_d = ST_RD_MASK;
            ST_RD_MASK:  state_d = ST_HOLDOFF;
            ST_IDLE: begin
                if (cfg_mask_i != mask_q) begin
                    state_d = ST_WR_MASK;
                end else if (int_ptp_i) begin
                    state_d = ST_RD_STAT;
                end
            end
            ST_RD_STAT:  state_d = ST_DISPATCH;
            ST_DISPATCH: state_d = ST_HOLDOFF;
            ST_HOLDOFF:  if (hold_q == '0) state_d = ST_IDLE;
            default:     state_d = ST_WR_MASK;
        endcase
    end

    // Bus strobes, address/data drive and event pulses decoded from the state.
    always_comb begin
        rd_ce   = 1'b0;
        wr_ce   = 1'b0;
        evt     = '0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            ST_WR_MASK: begin
                wr_ce   = 1'b1;
                addr_d  = INT_BASE_ADDR + MASK_OFS;
                wdata_d = {29'b0, cfg_mask_i};
            end
            ST_RD_MASK: begin
                rd_ce  = 1'b1;
                addr_d = INT_BASE_ADDR + MASK_OFS;
            end
            ST_RD_STAT: begin
                rd_ce  = 1'b1;
                addr_d = INT_BASE_ADDR + STAT_OFS;
            end
            ST_DISPATCH: evt = status_q;
            default: ;
        endcase
    end

    // Mask shadow, readback error, captured status and holdoff countdown.
    always_comb begin
        mask_d   = mask_q;
        err_d    = err_q;
        status_d = status_q;
        hold_d   = hold_q;
        unique case (state_q)
            ST_WR_MASK: mask_d = cfg_mask_i;
            ST_RD_MASK: if (bus.ip2bus_data[2:0] != mask_q) err_d = 1'b1;
            ST_RD_STAT: status_d = bus.ip2bus_data[2:0];
            ST_HOLDOFF: if (hold_q != '0) hold_d = hold_q - 1'b1;
            default: ;
        endcase
        if ((state_d == ST_HOLDOFF) && (state_q != ST_HOLDOFF)) begin
            hold_d = HOLD_LOAD;
        end
    end

    // Datapath registers.
    always_ff @(posedge bus2ip_clk) begin
        if (!bus2ip_rst_n) begin
            hold_q   <= '0;
            mask_q   <= '0;
            status_q <= '0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            hold_q   <= hold_d;
            mask_q   <= mask_d;
            status_q <= status_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    // NOTE: the FSM resets into WR_MASK, so state-decoded outputs are qualified with
    // bus2ip_rst_n to keep them at 0 while reset is held; the mask write then shows
    // up in the first cycle after release.
    assign bus.bus2ip_rd_ce = rd_ce & bus2ip_rst_n;
    assign bus.bus2ip_wr_ce = wr_ce & bus2ip_rst_n;
    assign bus.bus2ip_addr  = bus2ip_rst_n ? addr_d  : '0;
    assign bus.bus2ip_data  = bus2ip_rst_n ? wdata_d : '0;
    assign evt_xms_o        = evt[XMS] & bus2ip_rst_n;
    assign evt_rx_o         = evt[RX]  & bus2ip_rst_n;
    assign evt_tx_o         = evt[TX]  & bus2ip_rst_n;
    assign busy_o           = bus2ip_rst_n & (state_q != ST_IDLE);
    assign last_status_o    = status_q;
    assign cfg_err_o        = err_q;

    ptp_evt_cnt #(.CNT_W(CNT_W)) u_cnt_xms (
        .clk(bus2ip_clk), .rst_n(bus2ip_rst_n), .inc_i(evt_xms_o), .cnt_o(cnt_xms_o)
    );
    ptp_evt_cnt #(.CNT_W(CNT_W)) u_cnt_rx (
        .clk(bus2ip_clk), .rst_n(bus2ip_rst_n), .inc_i(evt_rx_o), .cnt_o(cnt_rx_o)
    );
    ptp_evt_cnt #(.CNT_W(CNT_W)) u_cnt_tx (
        .clk(bus2ip_clk), .rst_n(bus2ip_rst_n), .inc_i(evt_tx_o), .cnt_o(cnt_tx_o)
    );

endmodule

// File: tb/tb_ptp_int_svc.sv
// Bench for ptp_int_svc: a behavioural interrupt-controller slave (mask
// register, read-clear status, registered interrupt) plus a reference model of
// expected events and saturating counts. A second instance with narrow
// counters and a permanently asserted interrupt exercises saturation.
module tb_ptp_int_svc;
    import ptp_int_pkg::*;

    localparam int CW    = 16;
    localparam int CMAX  = (1 << CW) - 1;
    localparam int CW2   = 4;
    localparam int CMAX2 = (1 << CW2) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [2:0] cfg_mask;
    logic [2:0] src;
    logic       spur;
    logic       corrupt;
    logic       int_ptp;

    int vectors    = 0;
    int miscompares = 0;

    // ---------------- main DUT ----------------
    ptp_int_svc_if bus ();
    logic          evt_xms, evt_rx, evt_tx, cfg_err, busy;
    logic [CW-1:0] cnt_xms, cnt_rx, cnt_tx;
    logic [2:0]    last_status;

    ptp_int_svc #(.INT_BASE_ADDR(32'h0), .HOLDOFF(6), .CNT_W(CW)) dut (
        .bus2ip_clk(clk), .bus2ip_rst_n(rst_n), .int_ptp_i(int_ptp), .bus(bus),
        .cfg_mask_i(cfg_mask), .evt_xms_o(evt_xms), .evt_rx_o(evt_rx), .evt_tx_o(evt_tx),
        .cnt_xms_o(cnt_xms), .cnt_rx_o(cnt_rx), .cnt_tx_o(cnt_tx),
        .last_status_o(last_status), .cfg_err_o(cfg_err), .busy_o(busy)
    );

    // ---------------- slave model ----------------
    logic [2:0] s_mask, s_status;
    logic       s_int;
    logic [2:0] clr_v;
    logic [2:0] clr_b [3];

    always @(posedge clk) begin
        if (!rst_n) begin
            s_mask   <= '0;
            s_status <= '0;
            s_int    <= 1'b0;
            clr_v    <= '0;
            clr_b[0] <= '0; clr_b[1] <= '0; clr_b[2] <= '0;
        end else begin
            if (bus.bus2ip_wr_ce && bus.bus2ip_addr == 32'h1) s_mask <= bus.bus2ip_data[2:0];
            clr_v    <= {clr_v[1:0], bus.bus2ip_rd_ce && bus.bus2ip_addr == 32'h0};
            clr_b[0] <= s_status;
            clr_b[1] <= clr_b[0];
            clr_b[2] <= clr_b[1];
            s_status <= (s_status | (src & s_mask)) & ~(clr_v[2] ? clr_b[2] : 3'b000);
            s_int    <= |s_status;
        end
    end

    assign int_ptp = s_int | spur;
    assign bus.ip2bus_data = !bus.bus2ip_rd_ce ? 32'h0 :
                             (bus.bus2ip_addr == 32'h1) ? {29'h0, corrupt ? 3'b001 : s_mask} :
                             (bus.bus2ip_addr == 32'h0) ? {29'h0, s_status} : 32'h0;

    // ---------------- saturation DUT ----------------
    ptp_int_svc_if bus2 ();
    logic           evt_xms2, evt_rx2, evt_tx2, cfg_err2, busy2;
    logic [CW2-1:0] cnt_xms2, cnt_rx2, cnt_tx2;
    logic [2:0]     last_status2;

    ptp_int_svc #(.INT_BASE_ADDR(32'h0), .HOLDOFF(6), .CNT_W(CW2)) dut2 (
        .bus2ip_clk(clk), .bus2ip_rst_n(rst_n), .int_ptp_i(1'b1), .bus(bus2),
        .cfg_mask_i(3'b111), .evt_xms_o(evt_xms2), .evt_rx_o(evt_rx2), .evt_tx_o(evt_tx2),
        .cnt_xms_o(cnt_xms2), .cnt_rx_o(cnt_rx2), .cnt_tx_o(cnt_tx2),
        .last_status_o(last_status2), .cfg_err_o(cfg_err2), .busy_o(busy2)
    );
    assign bus2.ip2bus_data = !bus2.bus2ip_rd_ce ? 32'h0 :
                              (bus2.bus2ip_addr == 32'h1) ? 32'h7 : 32'h2;

    // ---------------- monitor ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_rd = 0, n_wr = 0, n_x = 0, n_r = 0, n_t = 0, n_rx2 = 0;
    int rd_cyc = 0, wr_cyc = 0, x_cyc = 0, r_cyc = 0, t_cyc = 0, irq_cyc = 0;
    logic [31:0] last_wdata = '0;
    logic prev_int = 1'b0;

    always @(negedge clk) begin
        prev_int <= int_ptp;
        if (int_ptp && !prev_int) irq_cyc <= cyc;
        if (!rst_n) begin
            n_rx2 <= 0;
        end else begin
            if (bus.bus2ip_rd_ce && bus.bus2ip_addr == 32'h0) begin n_rd <= n_rd + 1; rd_cyc <= cyc; end
            if (bus.bus2ip_wr_ce) begin n_wr <= n_wr + 1; wr_cyc <= cyc; last_wdata <= bus.bus2ip_data; end
            if (evt_xms) begin n_x <= n_x + 1; x_cyc <= cyc; end
            if (evt_rx)  begin n_r <= n_r + 1; r_cyc <= cyc; end
            if (evt_tx)  begin n_t <= n_t + 1; t_cyc <= cyc; end
            if (evt_rx2) n_rx2 <= n_rx2 + 1;
        end
    end

    // ---------------- reference model ----------------
    int         model_cnt [3];
    logic [2:0] model_last;
    int s_rd, s_wr, s_x, s_r, s_t;

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic model_reset();
        model_cnt[0] = 0; model_cnt[1] = 0; model_cnt[2] = 0;
        model_last = 3'b000;
    endtask

    task automatic model_events(input logic [2:0] bits);
        for (int i = 0; i < 3; i++) if (bits[i]) model_cnt[i] = sat_inc(model_cnt[i]);
        model_last = bits;
    endtask

    task automatic snap();
        s_rd = n_rd; s_wr = n_wr; s_x = n_x; s_r = n_r; s_t = n_t;
    endtask

    task automatic clocks(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic inject(input logic [2:0] bits);
        @(negedge clk); src = bits;
        @(negedge clk); src = 3'b000;
    endtask

    task automatic do_reset(input logic [2:0] mask);
        @(negedge clk);
        rst_n = 1'b0;
        cfg_mask = mask;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic check_counts(input string tag);
        vectors++;
        if (int'(cnt_xms) !== model_cnt[XMS] || int'(cnt_rx) !== model_cnt[RX] || int'(cnt_tx) !== model_cnt[TX]) begin
            miscompares++;
            $display("FAIL %s counts: got xms=%0d rx=%0d tx=%0d expected xms=%0d rx=%0d tx=%0d", tag,
                     cnt_xms, cnt_rx, cnt_tx, model_cnt[XMS], model_cnt[RX], model_cnt[TX]);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; cfg_mask = 3'b101;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        vectors++;
        if ({bus.bus2ip_wr_ce, bus.bus2ip_rd_ce, busy, cfg_err, evt_rx} !== 5'b0 || bus.bus2ip_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_quiet: got wr=%b rd=%b busy=%b err=%b addr=%0h expected all 0",
                     bus.bus2ip_wr_ce, bus.bus2ip_rd_ce, busy, cfg_err, bus.bus2ip_addr);
        end
        vectors++;
        if (cnt_rx !== '0 || cnt_xms !== '0 || cnt_tx !== '0 || last_status !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_regs: got cnt=%0h/%0h/%0h last=%b expected 0", cnt_xms, cnt_rx, cnt_tx, last_status);
        end
        rst_n = 1'b1;
        model_reset();
        #1;
        vectors++;
        if (bus.bus2ip_wr_ce !== 1'b1 || bus.bus2ip_rd_ce !== 1'b0 || bus.bus2ip_addr !== 32'h1 || bus.bus2ip_data !== 32'h5) begin
            miscompares++;
            $display("FAIL first_write: got wr=%b rd=%b addr=%0h data=%0h expected wr=1 rd=0 addr=1 data=5",
                     bus.bus2ip_wr_ce, bus.bus2ip_rd_ce, bus.bus2ip_addr, bus.bus2ip_data);
        end
        @(posedge clk); #1;
        vectors++;
        if (bus.bus2ip_rd_ce !== 1'b1 || bus.bus2ip_wr_ce !== 1'b0 || bus.bus2ip_addr !== 32'h1) begin
            miscompares++;
            $display("FAIL mask_readback: got rd=%b wr=%b addr=%0h expected rd=1 wr=0 addr=1",
                     bus.bus2ip_rd_ce, bus.bus2ip_wr_ce, bus.bus2ip_addr);
        end
        @(posedge clk); #1;
        vectors++;
        if (bus.bus2ip_rd_ce !== 1'b0 || bus.bus2ip_wr_ce !== 1'b0 || bus.bus2ip_addr !== 32'h1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL holdoff_entry: got rd=%b wr=%b addr=%0h busy=%b expected 0 0 1 1",
                     bus.bus2ip_rd_ce, bus.bus2ip_wr_ce, bus.bus2ip_addr, busy);
        end
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || cfg_err !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_init: got busy=%b err=%b expected 0 0", busy, cfg_err);
        end
    endtask

    task automatic test_cfg_err();
        corrupt = 1'b1;
        do_reset(3'b101);
        clocks(20);
        vectors++;
        if (cfg_err !== 1'b1) begin
            miscompares++;
            $display("FAIL cfg_err_set: got %b expected 1", cfg_err);
        end
        snap();
        inject(3'b100);
        model_events(3'b100);
        clocks(30);
        vectors++;
        if (cfg_err !== 1'b1 || (n_x - s_x) !== 1) begin
            miscompares++;
            $display("FAIL cfg_err_sticky: got err=%b xms_pulses=%0d expected err=1 pulses=1", cfg_err, n_x - s_x);
        end
        check_counts("cfg_err");
        corrupt = 1'b0;
        do_reset(3'b111);
        clocks(20);
        vectors++;
        if (cfg_err !== 1'b0 || cnt_xms !== '0) begin
            miscompares++;
            $display("FAIL cfg_err_cleared: got err=%b cnt_xms=%0d expected 0 0", cfg_err, cnt_xms);
        end
    endtask

    task automatic test_single_rx();
        snap();
        inject(3'b010);
        model_events(3'b010);
        clocks(30);
        vectors++;
        if ((n_rd - s_rd) !== 1 || last_status !== 3'b010) begin
            miscompares++;
            $display("FAIL single_rx_read: got reads=%0d status=%b expected 1 010", n_rd - s_rd, last_status);
        end
        vectors++;
        if ((n_r - s_r) !== 1 || (n_x - s_x) !== 0 || (n_t - s_t) !== 0) begin
            miscompares++;
            $display("FAIL single_rx_pulses: got x=%0d r=%0d t=%0d expected 0 1 0", n_x - s_x, n_r - s_r, n_t - s_t);
        end
        vectors++;
        if (rd_cyc !== irq_cyc + 1 || r_cyc !== irq_cyc + 2) begin
            miscompares++;
            $display("FAIL single_rx_latency: got rd=+%0d evt=+%0d expected rd=+1 evt=+2", rd_cyc - irq_cyc, r_cyc - irq_cyc);
        end
        check_counts("single_rx");
    endtask

    task automatic test_xms_tx();
        snap();
        inject(3'b101);
        model_events(3'b101);
        clocks(30);
        vectors++;
        if ((n_rd - s_rd) !== 1 || last_status !== 3'b101) begin
            miscompares++;
            $display("FAIL xms_tx_read: got reads=%0d status=%b expected 1 101", n_rd - s_rd, last_status);
        end
        vectors++;
        if ((n_x - s_x) !== 1 || (n_t - s_t) !== 1 || (n_r - s_r) !== 0 || x_cyc !== t_cyc) begin
            miscompares++;
            $display("FAIL xms_tx_pulses: got x=%0d r=%0d t=%0d xcyc=%0d tcyc=%0d expected 1 0 1 same cycle",
                     n_x - s_x, n_r - s_r, n_t - s_t, x_cyc, t_cyc);
        end
        check_counts("xms_tx");
    endtask

    task automatic test_mask_change();
        snap();
        inject(3'b010);
        for (int i = 0; i < 10 && !int_ptp; i++) begin @(posedge clk); #1; end
        vectors++;
        if (int_ptp !== 1'b1) begin
            miscompares++;
            $display("FAIL mask_change_irq: got int=%b expected 1 within budget", int_ptp);
        end
        cfg_mask = 3'b011;
        model_events(3'b010);
        clocks(40);
        vectors++;
        if ((n_wr - s_wr) !== 1 || last_wdata !== 32'h3 || !(wr_cyc < rd_cyc)) begin
            miscompares++;
            $display("FAIL mask_change_order: got writes=%0d data=%0h wr_cyc=%0d rd_cyc=%0d expected 1 write of 3 before read",
                     n_wr - s_wr, last_wdata, wr_cyc, rd_cyc);
        end
        vectors++;
        if ((n_rd - s_rd) !== 1 || (n_r - s_r) !== 1 || last_status !== 3'b010) begin
            miscompares++;
            $display("FAIL mask_change_event: got reads=%0d rx=%0d status=%b expected 1 1 010",
                     n_rd - s_rd, n_r - s_r, last_status);
        end
        check_counts("mask_change");
    endtask

    task automatic test_spurious();
        bit seen;
        snap();
        seen = 1'b0;
        @(negedge clk); spur = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk); #1;
            if (bus.bus2ip_rd_ce && bus.bus2ip_addr == 32'h0) seen = 1'b1;
        end
        spur = 1'b0;
        model_events(3'b000);
        clocks(30);
        vectors++;
        if (!seen || (n_rd - s_rd) !== 1 || last_status !== 3'b000) begin
            miscompares++;
            $display("FAIL spurious_read: got seen=%b reads=%0d status=%b expected 1 1 000", seen, n_rd - s_rd, last_status);
        end
        vectors++;
        if ((n_x - s_x) !== 0 || (n_r - s_r) !== 0 || (n_t - s_t) !== 0) begin
            miscompares++;
            $display("FAIL spurious_pulses: got x=%0d r=%0d t=%0d expected none", n_x - s_x, n_r - s_r, n_t - s_t);
        end
        check_counts("spurious");
    endtask

    task automatic test_random();
        logic [2:0] m, b, e;
        for (int it = 0; it < 24; it++) begin
            m = 3'($urandom_range(0, 7));
            b = 3'($urandom_range(1, 7));
            e = b & m;
            @(negedge clk); cfg_mask = m;
            clocks(20);
            snap();
            inject(b);
            if (e != 3'b000) model_events(e);
            clocks(25);
            vectors++;
            if ((n_rd - s_rd) !== ((e != 3'b000) ? 1 : 0) || last_status !== model_last) begin
                miscompares++;
                $display("FAIL random_read it=%0d m=%b b=%b: got reads=%0d status=%b expected %0d %b",
                         it, m, b, n_rd - s_rd, last_status, (e != 3'b000) ? 1 : 0, model_last);
            end
            vectors++;
            if ((n_x - s_x) !== int'(e[XMS]) || (n_r - s_r) !== int'(e[RX]) || (n_t - s_t) !== int'(e[TX])) begin
                miscompares++;
                $display("FAIL random_pulses it=%0d: got x=%0d r=%0d t=%0d expected %b",
                         it, n_x - s_x, n_r - s_r, n_t - s_t, e);
            end
            check_counts("random");
        end
        vectors++;
        if (cfg_err !== 1'b0) begin
            miscompares++;
            $display("FAIL random_cfg_err: got %b expected 0", cfg_err);
        end
    endtask

    task automatic test_saturation();
        int exp_rx2;
        exp_rx2 = (n_rx2 > CMAX2) ? CMAX2 : n_rx2;
        vectors++;
        if (n_rx2 <= CMAX2) begin
            miscompares++;
            $display("FAIL sat_pulses: got %0d rx pulses expected more than %0d", n_rx2, CMAX2);
        end
        vectors++;
        if (int'(cnt_rx2) !== exp_rx2 || cnt_xms2 !== '0 || cnt_tx2 !== '0) begin
            miscompares++;
            $display("FAIL sat_count: got rx=%0d xms=%0d tx=%0d expected %0d 0 0", cnt_rx2, cnt_xms2, cnt_tx2, exp_rx2);
        end
    endtask

    initial begin
        rst_n = 1'b0; cfg_mask = 3'b101; src = 3'b000; spur = 1'b0; corrupt = 1'b0;
        model_reset();
        test_reset();
        test_cfg_err();
        test_single_rx();
        test_xms_tx();
        test_mask_change();
        test_spurious();
        test_random();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
